// File: rtl/dms_lpf_ctrl.sv
// Loop-filter bring-up sequencer: precharge, settle, acquire, track, with
// window-violation fault latching. Outputs are registered decodes of the state.
module dms_lpf_ctrl #(
    parameter int PCHG_CYC   = 64,
    parameter int SETTLE_CYC = 32,
    parameter int LOCK_CYC   = 16,
    parameter int CW         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       vc_hi,
    input  logic       vc_lo,
    input  logic       lock_in,
    output logic       pchg_en,
    output logic       cp_en,
    output logic       locked,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PCHG   = 3'd1,
        SETTLE = 3'd2,
        ACQ    = 3'd3,
        TRACK  = 3'd4,
        FAULT  = 3'd5
    } st_t;

    localparam logic [CW-1:0] PCHG_LAST   = CW'(PCHG_CYC - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_CYC - 1);

    st_t           st, nxt;
    logic [CW-1:0] cnt;
    logic          viol;

    assign viol  = vc_hi | vc_lo;
    assign state = st;

    always_comb begin
        nxt = st;
        if (!en) begin
            nxt = IDLE;
        end else begin
            case (st)
                IDLE:    nxt = PCHG;
                PCHG:    if (cnt == PCHG_LAST) nxt = viol ? FAULT : SETTLE;
                SETTLE:  if (cnt == SETTLE_LAST) nxt = ACQ;
                ACQ: begin
                    if (viol)                              nxt = FAULT;
                    else if (lock_in && cnt == LOCK_LAST) nxt = TRACK;
                end
                TRACK: begin
                    if (viol)          nxt = FAULT;
                    else if (!lock_in) nxt = ACQ;
                end
                FAULT:   nxt = FAULT;
                default: nxt = IDLE;
            endcase
        end
    end

    // Counter saturates instead of wrapping while a state is held indefinitely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= IDLE;
            cnt     <= '0;
            pchg_en <= 1'b0;
            cp_en   <= 1'b0;
            locked  <= 1'b0;
            fault   <= 1'b0;
        end else begin
            st <= nxt;
            if (nxt != st || (st == ACQ && !lock_in))
                cnt <= '0;
            else if (cnt != '1)
                cnt <= cnt + 1'b1;
            pchg_en <= (nxt == PCHG);
            cp_en   <= (nxt == ACQ) || (nxt == TRACK);
            locked  <= (nxt == TRACK);
            fault   <= (nxt == FAULT);
        end
    end

endmodule

// File: tb/tb_dms_lpf_ctrl.sv
// Directed bench for dms_lpf_ctrl: per-cycle check against a phase/age model
// plus literal expectations for bring-up, lock glitch, faults, priority, reset.
module tb_dms_lpf_ctrl;
    localparam int P = 4, S = 2, L = 3;

    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, vc_hi = 1'b0, vc_lo = 1'b0, lock_in = 1'b0;
    logic pchg_en, cp_en, locked, fault;
    logic [2:0] state;

    int n_chk = 0, n_err = 0;
    int m_st = 0, m_age = 0, m_run = 0;

    dms_lpf_ctrl #(.PCHG_CYC(P), .SETTLE_CYC(S), .LOCK_CYC(L), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .vc_hi(vc_hi), .vc_lo(vc_lo),
        .lock_in(lock_in), .pchg_en(pchg_en), .cp_en(cp_en), .locked(locked),
        .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: phase number, cycles spent in the phase, run of lock highs in ACQ.
    always @(posedge clk or negedge rst_n) begin
        int nx;
        if (!rst_n) begin
            m_st = 0; m_age = 0; m_run = 0;
        end else begin
            nx = m_st;
            if (!en) nx = 0;
            else if (m_st == 0) nx = 1;
            else if (m_st == 1) begin
                if (m_age == P - 1) nx = (vc_hi || vc_lo) ? 5 : 2;
            end else if (m_st == 2) begin
                if (m_age == S - 1) nx = 3;
            end else if (m_st == 3) begin
                if (vc_hi || vc_lo) nx = 5;
                else if (lock_in && m_run + 1 >= L) nx = 4;
            end else if (m_st == 4) begin
                if (vc_hi || vc_lo) nx = 5;
                else if (!lock_in) nx = 3;
            end
            m_run = (m_st == 3 && nx == 3 && lock_in) ? m_run + 1 : 0;
            m_age = (nx == m_st) ? m_age + 1 : 0;
            m_st  = nx;
        end
    end

    always @(negedge clk) begin
        chk("state",   32'(state),   32'(m_st));
        chk("pchg_en", 32'(pchg_en), 32'(m_st == 1));
        chk("cp_en",   32'(cp_en),   32'(m_st == 3 || m_st == 4));
        chk("locked",  32'(locked),  32'(m_st == 4));
        chk("fault",   32'(fault),   32'(m_st == 5));
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int pc, cp_first, lk_first, quiet, first_st;
        int pat[6] = '{1, 1, 0, 1, 1, 1};

        step(2);
        chk("rst_outputs", 32'({pchg_en, cp_en, locked, fault}), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        rst_n = 1'b1;

        // Nominal bring-up
        en = 1'b1; lock_in = 1'b1;
        pc = 0; cp_first = 0; lk_first = 0; quiet = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            if (pchg_en) pc++;
            if (cp_en && cp_first == 0) cp_first = i;
            if (locked && lk_first == 0) lk_first = i;
            if (state != 3'd0 && !pchg_en && !cp_en && !locked && !fault) quiet++;
        end
        chk("bring_pchg_cycles", 32'(pc), 32'd4);
        chk("bring_quiet_cycles", 32'(quiet), 32'd2);
        chk("bring_cp_edge", 32'(cp_first), 32'd7);
        chk("bring_lock_edge", 32'(lk_first), 32'd10);

        // Lock drop in TRACK then glitchy reacquire
        lock_in = 1'b0; step(1);
        chk("drop_state", 32'(state), 32'd3);
        chk("drop_locked", 32'(locked), 32'd0);
        for (int k = 0; k < 6; k++) begin
            lock_in = pat[k][0];
            step(1);
            if (k == 4) chk("glitch_not_yet", 32'(state), 32'd3);
            if (k == 5) chk("glitch_track", 32'(state), 32'd4);
        end

        // Window violation in TRACK
        vc_hi = 1'b1; step(1);
        chk("trk_viol_state", 32'(state), 32'd5);
        chk("trk_viol_outs", 32'({cp_en, locked, fault}), 32'b001);
        vc_hi = 1'b0; step(3);
        chk("fault_held", 32'(state), 32'd5);
        en = 1'b0; step(1);
        chk("fault_exit", 32'(state), 32'd0);

        // Precharge failure: vc_lo ignored until the last PCHG cycle
        en = 1'b1; vc_lo = 1'b1; lock_in = 1'b0;
        step(4);
        chk("pchg_vc_ignored", 32'(state), 32'd1);
        step(1);
        chk("pchg_fail_state", 32'(state), 32'd5);
        chk("pchg_fail_outs", 32'({cp_en, fault}), 32'b01);
        vc_lo = 1'b0; step(2);
        chk("pchg_fail_held", 32'(fault), 32'd1);
        en = 1'b0; step(1);
        chk("pchg_fail_exit", 32'(state), 32'd0);

        // SETTLE ignores window; en=0 beats violation in ACQ
        en = 1'b1; step(5);
        vc_hi = 1'b1; step(2);
        chk("settle_vc_ignored", 32'(state), 32'd3);
        vc_hi = 1'b0; step(3);
        chk("acq_hold", 32'(state), 32'd3);
        en = 1'b0; vc_hi = 1'b1; step(1);
        chk("prio_state", 32'(state), 32'd0);
        chk("prio_fault", 32'(fault), 32'd0);
        vc_hi = 1'b0;

        // Asynchronous reset mid-PCHG
        en = 1'b1; step(2);
        chk("pre_rst_pchg", 32'(pchg_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pchg", 32'(pchg_en), 32'd0);
        chk("async_rst_state", 32'(state), 32'd0);
        step(1);
        rst_n = 1'b1;
        pc = 0; first_st = -1;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            if (i == 1) first_st = int'(state);
            if (pchg_en) pc++;
        end
        chk("rerun_first_state", 32'(first_st), 32'd1);
        chk("rerun_pchg_cycles", 32'(pc), 32'd4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
